// File: rtl/bus_launch_pkg.sv
// Shared types and constants for the bus_launch source-side launcher.
package bus_launch_pkg;
  localparam int CNT_W    = 8;
  localparam int DEF_HOLD = 4;
  localparam int DEF_GAP  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;
endpackage

// File: rtl/bus_launch.sv
// Launches one word toward a destination-domain synchronizer: bus_enable high HOLD_CYCLES, low GAP_CYCLES.
// One word per HOLD+GAP+1 cycles; producer backpressure is carried only by in_ready (high in IDLE).
module bus_launch
  import bus_launch_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = DEF_HOLD,
  parameter int GAP_CYCLES  = DEF_GAP
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 tx_done
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BUS_WIDTH-1:0] bus_nxt;
  logic                 en_nxt;
  logic                 done_nxt;

  assign in_ready = (state == ST_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bus_nxt   = unsync_bus;
    en_nxt    = bus_enable;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LOAD;
          bus_nxt   = in_data;
          en_nxt    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_LOAD;
          en_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        // Unused encoding: recover to IDLE with the qualifier dropped.
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        en_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      unsync_bus <= bus_nxt;
      bus_enable <= en_nxt;
      tx_done    <= done_nxt;
    end
  end

endmodule
